// File: rtl/bp_pht_port_scheduler.sv
// Arbitrates the single PHT port between fetch lookups and buffered
// execute-stage updates, and sweeps the table to weakly-not-taken after reset/clear.
module bp_pht_port_scheduler #(
   parameter int PC_WIDTH   = 32,
   parameter int INDEX_BITS = 6,
   parameter int UQ_DEPTH   = 4,
   parameter int MAX_DEFER  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  lk_valid,
   input  logic [PC_WIDTH-1:0]   lk_pc,
   output logic                  lk_ready,
   input  logic                  upd_valid,
   input  logic [PC_WIDTH-1:0]   upd_pc,
   input  logic                  upd_taken,
   output logic                  upd_ready,
   output logic                  pred_valid,
   output logic                  pred_taken,
   output logic                  busy_init,
   output logic                  pht_en,
   output logic                  pht_we,
   output logic [INDEX_BITS-1:0] pht_idx,
   output logic [1:0]            pht_wdata,
   input  logic [1:0]            pht_rdata
);

   localparam int PTR_W = (UQ_DEPTH > 1) ? $clog2(UQ_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int DEF_W = $clog2(MAX_DEFER + 1);

   localparam logic [1:0] ST_RST    = 2'd0;
   localparam logic [1:0] ST_INIT   = 2'd1;
   localparam logic [1:0] ST_RUN    = 2'd2;
   localparam logic [1:0] ST_UPD_WR = 2'd3;

   logic [1:0]            state, state_nxt;
   logic [INDEX_BITS-1:0] init_cnt;
   logic [DEF_W-1:0]      defer_cnt;
   logic [INDEX_BITS-1:0] fifo_idx   [UQ_DEPTH];
   logic                  fifo_taken [UQ_DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0]      count;

   logic                  fifo_empty, fifo_full, push, pop, grant, start_upd;
   logic [INDEX_BITS-1:0] lk_idx, head_idx;
   logic                  head_taken;
   logic [1:0]            upd_wdata;
   logic                  unused_pc_bits;

   assign lk_idx     = lk_pc[INDEX_BITS+1:2];
   assign head_idx   = fifo_idx[rd_ptr];
   assign head_taken = fifo_taken[rd_ptr];
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CNT_W'(UQ_DEPTH));
   assign upd_ready  = !fifo_full;
   assign push       = upd_valid && upd_ready && !clear;
   assign busy_init  = (state == ST_RST) || (state == ST_INIT);
   assign pred_taken = pred_valid & pht_rdata[1];
   assign unused_pc_bits = ^{lk_pc[PC_WIDTH-1:INDEX_BITS+2], lk_pc[1:0],
                             upd_pc[PC_WIDTH-1:INDEX_BITS+2], upd_pc[1:0]};

   // Two-bit saturating counter step toward the resolved direction.
   always_comb begin
      upd_wdata = pht_rdata;
      if (head_taken) begin
         if (pht_rdata != 2'b11) upd_wdata = pht_rdata + 2'b01;
      end else begin
         if (pht_rdata != 2'b00) upd_wdata = pht_rdata - 2'b01;
      end
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      lk_ready  = 1'b0;
      pht_en    = 1'b0;
      pht_we    = 1'b0;
      pht_idx   = '0;
      pht_wdata = 2'b00;
      grant     = 1'b0;
      start_upd = 1'b0;
      pop       = 1'b0;
      if (clear) begin
         state_nxt = ST_INIT;
      end else begin
         case (state)
            ST_RST: state_nxt = ST_INIT;
            ST_INIT: begin
               pht_en    = 1'b1;
               pht_we    = 1'b1;
               pht_idx   = init_cnt;
               pht_wdata = 2'b01;
               if (init_cnt == '1) state_nxt = ST_RUN;
            end
            ST_RUN: begin
               // A starving update wins over lookups once deferral is exhausted.
               if (!fifo_empty && (fifo_full || defer_cnt == DEF_W'(MAX_DEFER)))
                  start_upd = 1'b1;
               else if (lk_valid)
                  grant = 1'b1;
               else if (!fifo_empty)
                  start_upd = 1'b1;
               if (grant) begin
                  lk_ready = 1'b1;
                  pht_en   = 1'b1;
                  pht_idx  = lk_idx;
               end
               if (start_upd) begin
                  pht_en    = 1'b1;
                  pht_idx   = head_idx;
                  state_nxt = ST_UPD_WR;
               end
            end
            default: begin
               pht_en    = 1'b1;
               pht_we    = 1'b1;
               pht_idx   = head_idx;
               pht_wdata = upd_wdata;
               pop       = 1'b1;
               state_nxt = ST_RUN;
            end
         endcase
      end
   end

   // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_RST;
         init_cnt   <= '0;
         defer_cnt  <= '0;
         pred_valid <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
      end else begin
         state      <= state_nxt;
         pred_valid <= grant;
         if (clear) begin
            init_cnt  <= '0;
            defer_cnt <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
         end else begin
            if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
            if (start_upd)
               defer_cnt <= '0;
            else if (grant && !fifo_empty)
               defer_cnt <= defer_cnt + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   // NOTE: FIFO payload has no reset; occupancy is tracked by count, so stale entries are never used.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_idx[wr_ptr]   <= upd_pc[INDEX_BITS+1:2];
         fifo_taken[wr_ptr] <= upd_taken;
      end
   end

endmodule
